// File: rtl/hash_pkg.sv
// Shared types, default sizes and address mapping for the hash vector assembler.
package hash_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    localparam int unsigned HASH_WORD_WIDTH = 32;
    localparam int unsigned HASH_NUM_WORDS  = 8;

    // Word address width; never narrower than one bit so NUM_WORDS = 1 still has an address port.
    function automatic int unsigned addr_width(input int unsigned num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    // Word order 0 keeps address k in slot k; word order 1 puts address 0 in the top slot (digest order).
    function automatic int unsigned addr_to_slot(input int unsigned addr, input logic word_order,
                                                 input int unsigned num_words);
        return word_order ? (num_words - 1 - addr) : addr;
    endfunction

endpackage

// File: rtl/hash_vector_assembler_if.sv
// Write port and vector output handshake of the hash vector assembler.
interface hash_vector_assembler_if
    import hash_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = HASH_WORD_WIDTH,
    parameter int unsigned NUM_WORDS  = HASH_NUM_WORDS
);
    localparam int unsigned ADDR_W = addr_width(NUM_WORDS);
    localparam int unsigned VEC_W  = WORD_WIDTH * NUM_WORDS;

    logic                  wr_valid;
    logic [ADDR_W-1:0]     wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [VEC_W-1:0]      out_vector;
    logic [NUM_WORDS-1:0]  fill_mask;
    logic                  dup_err;
    logic                  addr_err;

    modport master (
        output wr_valid, wr_addr, wr_data, out_ready,
        input  wr_ready, out_valid, out_vector, fill_mask, dup_err, addr_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, out_ready,
        output wr_ready, out_valid, out_vector, fill_mask, dup_err, addr_err
    );

endinterface

// File: rtl/hash_slot_decoder.sv
// Turns an accepted word address into a one-hot slot write enable plus a range flag.
module hash_slot_decoder
    import hash_pkg::*;
#(
    parameter int unsigned NUM_WORDS = HASH_NUM_WORDS,
    parameter int unsigned ADDR_W    = addr_width(NUM_WORDS)
) (
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic                 word_order,
    input  logic                 accept,
    output logic [NUM_WORDS-1:0] slot_we,
    output logic                 in_range
);

    // Range check first so an out-of-range address never maps through the reversed order.
    always_comb begin
        in_range = (32'(wr_addr) < NUM_WORDS);
        slot_we  = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            slot_we[k] = accept && in_range &&
                         (addr_to_slot(32'(wr_addr), word_order, NUM_WORDS) == k);
        end
    end

endmodule

// File: rtl/hash_vector_assembler.sv
// Collects NUM_WORDS words in any order into one vector and hands it off via valid/ready.
module hash_vector_assembler
    import hash_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = HASH_WORD_WIDTH,
    parameter int unsigned NUM_WORDS  = HASH_NUM_WORDS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    word_order,
    hash_vector_assembler_if.slave  bus
);

    localparam int unsigned ADDR_W = addr_width(NUM_WORDS);
    localparam int unsigned VEC_W  = WORD_WIDTH * NUM_WORDS;

    state_e               state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [NUM_WORDS-1:0] mask_q, mask_d;
    logic                 dup_q, dup_d;
    logic                 aerr_q, aerr_d;

    logic                 accept;
    logic                 in_range;
    logic                 flush;
    logic [NUM_WORDS-1:0] slot_we;

    // Acceptance uses the state directly so clear can drop a same-cycle write without a comb loop through wr_ready.
    assign accept = bus.wr_valid && (state_q == COLLECT) && !clear;
    assign flush  = clear || ((state_q == FULL) && bus.out_ready);

    hash_slot_decoder #(
        .NUM_WORDS (NUM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_decoder (
        .wr_addr    (bus.wr_addr),
        .word_order (word_order),
        .accept     (accept),
        .slot_we    (slot_we),
        .in_range   (in_range)
    );

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_slot
        assign vec_d[k*WORD_WIDTH +: WORD_WIDTH] =
            flush      ? '0 :
            slot_we[k] ? bus.wr_data : vec_q[k*WORD_WIDTH +: WORD_WIDTH];
        assign mask_d[k] = !flush && (slot_we[k] || mask_q[k]);
    end

    assign dup_d  = |(slot_we & mask_q);
    assign aerr_d = accept && !in_range;

    // Next state and handshake outputs; FULL is entered on the write that completes the mask.
    always_comb begin
        state_d       = state_q;
        bus.wr_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                bus.wr_ready = 1'b1;
                if (&mask_d) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        if (clear) begin
            state_d = COLLECT;
        end
    end

    // State, vector, mask and error pulse registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COLLECT;
            vec_q   <= '0;
            mask_q  <= '0;
            dup_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            dup_q   <= dup_d;
            aerr_q  <= aerr_d;
        end
    end

    assign bus.out_vector = vec_q;
    assign bus.fill_mask  = mask_q;
    assign bus.dup_err    = dup_q;
    assign bus.addr_err   = aerr_q;

endmodule
